alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 23 ++
 rtl/alu_issue_fifo.sv | 64 ++++++
 rtl/alu_issue.sv | 115 +++++++++++
 tb/tb_alu_issue.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types and constants for the ALU issue queue
package alu_issue_pkg;

    localparam int CTRL_W     = 4;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] in1;
        logic [DATA_W_DEF-1:0] in2;
        logic [CTRL_W-1:0]     control;
    } cmd_t;

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// rtl/alu_issue_fifo.sv - command queue storage, wrapping pointers and occupancy level
module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = 2 * DATA_W_DEF + CTRL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_level = r_level;

    // Empty queue presents zeros so the downstream ALU never sees stale entries.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - queues ALU commands, issues the head and registers the result
// Optional issue counter output enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DATA_W-1:0]      cmd_in1,
    input  logic [DATA_W-1:0]      cmd_in2,
    input  logic [CTRL_W-1:0]      cmd_control,
    output logic [DATA_W-1:0]      alu_in1,
    output logic [DATA_W-1:0]      alu_in2,
    output logic [CTRL_W-1:0]      alu_control,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_W-1:0]      res_out,
    output logic                   res_zero,
    output logic                   res_neg,
    output logic [$clog2(DEPTH):0] level
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]            issue_count
`endif
);

    localparam int CMD_W = 2 * DATA_W + CTRL_W;

    logic [CMD_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    res_state_t        r_state;
    logic [DATA_W-1:0] r_res_out;
    logic              r_res_zero;
    logic              r_res_neg;

    alu_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_in1, cmd_in2, cmd_control}),
        .i_pop   (w_issue),
        .o_rdata (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cmd_ready = !w_full;
    assign {alu_in1, alu_in2, alu_control} = w_head;

    // The ALU is combinational, so the head result is valid in the issue cycle.
    assign w_issue = !w_empty && ((r_state == RES_EMPTY) || res_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RES_EMPTY;
            r_res_out  <= '0;
            r_res_zero <= 1'b0;
            r_res_neg  <= 1'b0;
        end else begin
            case (r_state)
                RES_EMPTY: begin
                    if (w_issue) begin
                        r_state    <= RES_FULL;
                        r_res_out  <= alu_out;
                        r_res_zero <= alu_zero;
                        r_res_neg  <= alu_neg;
                    end
                end
                RES_FULL: begin
                    if (w_issue) begin
                        r_res_out  <= alu_out;
                        r_res_zero <= alu_zero;
                        r_res_neg  <= alu_neg;
                    end else if (res_ready) begin
                        r_state <= RES_EMPTY;
                    end
                end
                default: r_state <= RES_EMPTY;
            endcase
        end
    end

    assign res_valid = (r_state == RES_FULL);
    assign res_out   = r_res_out;
    assign res_zero  = r_res_zero;
    assign res_neg   = r_res_neg;

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] r_issue_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_count <= '0;
        end else if (w_issue) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign issue_count = r_issue_count;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized and directed bench for alu_issue with a queue-based reference model
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_in1;
    logic [DW-1:0] cmd_in2;
    logic [3:0]    cmd_control;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [3:0]    alu_control;
    logic [DW-1:0] alu_out;
    logic          alu_zero;
    logic          alu_neg;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_out;
    logic          res_zero;
    logic          res_neg;
    logic [$clog2(DEPTH):0] level;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0]   issue_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    cmd_t        mq[$];
    cmd_t        got_q[$];
    cmd_t        m_reg;
    bit          m_rv;
    logic [DW-1:0] m_out;
    bit          m_zero;
    bit          m_neg;
    int unsigned m_issues;
    logic [3:0]  ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd15};

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_in1     (cmd_in1),
        .cmd_in2     (cmd_in2),
        .cmd_control (cmd_control),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_out     (res_out),
        .res_zero    (res_zero),
        .res_neg     (res_neg),
        .level       (level)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .issue_count (issue_count)
`endif
    );

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_fn(alu_in1, alu_in2, alu_control);
        alu_zero = (alu_out == '0);
        alu_neg  = alu_out[DW-1];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        got_q.delete();
        m_rv     = 1'b0;
        m_out    = '0;
        m_zero   = 1'b0;
        m_neg    = 1'b0;
        m_issues = 0;
    endtask

    task automatic rand_cmd();
        cmd_in1     = $urandom;
        cmd_in2     = ($urandom_range(0, 3) == 0) ? cmd_in1 : $urandom;
        cmd_control = ops[$urandom_range(0, 7)];
    endtask

    // Compare against the model just before the edge, then advance the model by one cycle.
    task automatic tick();
        bit   push;
        bit   issue;
        cmd_t head;
        cmd_t cur;
        @(negedge clk);
        if (!rst) begin
            head = (mq.size() != 0) ? mq[0] : '0;
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, mq.size() != DEPTH});
            chk("level", 32'(level), 32'(mq.size()));
            chk("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
            chk("res_out", res_out, m_out);
            chk("res_flags", {30'd0, res_zero, res_neg}, {30'd0, m_zero, m_neg});
            chk("alu_in1", alu_in1, head.in1);
            chk("alu_in2_ctrl", alu_in2 ^ {28'd0, alu_control}, head.in2 ^ {28'd0, head.control});
`ifdef ALU_ISSUE_PERF_EN
            chk("issue_count", {16'd0, issue_count}, {16'd0, m_issues[15:0]});
`endif
            cur.in1     = cmd_in1;
            cur.in2     = cmd_in2;
            cur.control = cmd_control;
            push  = cmd_valid && (mq.size() != DEPTH);
            issue = (mq.size() != 0) && (!m_rv || res_ready);
            if (m_rv && res_ready) got_q.push_back(m_reg);
            if (issue) begin
                m_reg  = mq.pop_front();
                m_out  = alu_fn(m_reg.in1, m_reg.in2, m_reg.control);
                m_zero = (m_out == '0);
                m_neg  = m_out[DW-1];
                m_rv   = 1'b1;
                m_issues++;
            end else if (res_ready) begin
                m_rv = 1'b0;
            end
            if (push) mq.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t cs [6];

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        res_ready   = 1'b0;
        cmd_in1     = '0;
        cmd_in2     = '0;
        cmd_control = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_out", res_out, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        rst = 1'b0;

        // Single command 5 + 7.
        cmd_in1 = 32'd5; cmd_in2 = 32'd7; cmd_control = 4'd2;
        cmd_valid = 1'b1; res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("single_rv_after_push", {31'd0, res_valid}, 32'd0);
        chk("single_level_after_push", 32'(level), 32'd1);
        tick();
        chk("single_rv", {31'd0, res_valid}, 32'd1);
        chk("single_res", res_out, 32'd12);
        chk("single_flags", {30'd0, res_zero, res_neg}, 32'd0);
        chk("single_level", 32'(level), 32'd0);
        tick();

        // Back-pressure: six attempts, one lands in the register, four queue up.
        got_q.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_cmd();
            cs[i].in1 = cmd_in1; cs[i].in2 = cmd_in2; cs[i].control = cmd_control;
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_level", 32'(level), 32'd4);
        chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        repeat (5) tick();
        chk("bp_drained", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            chk("bp_order_in1", got_q[i].in1, cs[i].in1);
            chk("bp_order_in2", got_q[i].in2, cs[i].in2);
        end
        tick();
        chk("bp_empty_rv", {31'd0, res_valid}, 32'd0);

        // Streaming 20 commands with the consumer always ready.
        got_q.delete();
        for (int i = 0; i < 20; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
            chk("stream_level", 32'(level), 32'd1);
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("stream_count", 32'(got_q.size()), 32'd20);

        // Full queue rejects, then push+pop at level 3 across pointer wrap.
        got_q.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        rand_cmd();
        tick();
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("pp_level_pre", 32'(level), 32'd3);
        for (int i = 0; i < 6; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
            chk("pp_level", 32'(level), 32'd3);
        end
        cmd_valid = 1'b0;
        repeat (6) tick();
        chk("pp_count", 32'(got_q.size()), 32'd11);
        chk("pp_level_end", 32'(level), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_cmd();
            cmd_valid = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (6) tick();
        chk("rand_level_end", 32'(level), 32'd0);
        chk("rand_rv_end", {31'd0, res_valid}, 32'd0);

        // Asynchronous reset with level 3 and a pending result.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        chk("prerst_level", 32'(level), 32'd3);
        chk("prerst_rv", {31'd0, res_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_res_out", res_out, 32'd0);
        chk("arst_flags", {30'd0, res_zero, res_neg}, 32'd0);
        chk("arst_alu", alu_in1 | alu_in2 | {28'd0, alu_control}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        rand_cmd();
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("postrst_results", 32'(got_q.size()), 32'd1);

`ifdef ALU_ISSUE_PERF_EN
        rst = 1'b1;
        #1;
        chk("perf_rst", {16'd0, issue_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            cmd_in1 = i; cmd_in2 = 32'd3; cmd_control = 4'd2;
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("perf_wrap", {16'd0, issue_count}, 32'd4464);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
